rr_multi_priority_finder: RTL
=============================

Name: rr_multi_priority_finder

Overview:
- Parametrised successor to the single-grant priority finder.
- Each cycle, selects up to GRANT_NUM set bits from a WIDTH-bit request vector.
- Search starts at a registered rotating pointer (round-robin mode) or at a fixed end (fixed mode).
- Used by issue/allocation logic (free-list slots, issue-queue entries, writeback ports) that needs multiple fair grants per cycle with a consumer accept handshake.

Parameters:
- WIDTH, 8, request vector width; power of 2, >= 1.
- GRANT_NUM, 2, number of grant outputs; 1..WIDTH.
- ROUND_ROBIN, 1, 1 = search starts at ptr and rotates on accept; 0 = fixed priority, ptr held at 0.
- FIRST_PRIORITY, 1, fixed mode only: 1 = lowest index highest priority; 0 = highest index highest priority.
- IDXW, derived as max(clog2(WIDTH),1); not overridable.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- data_in  input  WIDTH  request vector
- accept  input  1  consumer takes all currently valid grants this cycle
- flush  input  1  synchronous pointer return to 0
- grant_index  output  GRANT_NUM x IDXW  index of k-th grant
- grant_valid  output  GRANT_NUM  k-th grant present
- grant_mask  output  WIDTH  one-hot OR of all valid grants
- ptr  output  IDXW  current search start pointer

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- State: ptr register only. Grant outputs are combinational from data_in and ptr (zero-latency).
- Reset: ptr = 0, asserted immediately on rst rise, independent of clk. With ptr = 0, outputs follow the search rule.
- All-zero output: when data_in = 0, grant_valid = 0, grant_index = 0 for all k, grant_mask = 0.
- Round-robin search order: ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1 (mod WIDTH).
- Fixed search order: FIRST_PRIORITY=1 gives 0..WIDTH-1; FIRST_PRIORITY=0 gives WIDTH-1..0.
- Grant k: the (k+1)-th set bit of data_in in search order. grant_valid[k]=0 if fewer than k+1 bits are set.
- Valid grants are packed: grant_valid is thermometer (valid[k] implies valid[k-1]). Each valid grant_index is distinct.
- Invalid slot: grant_index[k] = 0.
- Pointer update at posedge clk, priority order:
  - rst: ptr = 0 (async, overrides all).
  - flush: ptr <= 0, even if accept is high.
  - ROUND_ROBIN && accept && grant_valid[0]: ptr <= (index of last valid grant + 1) mod WIDTH.
  - otherwise: ptr holds.
- accept with no valid grant: no effect.
- ROUND_ROBIN=0: ptr constant 0. accept and flush have no state effect.
- Wrap-around: ptr + 1 wraps WIDTH-1 to 0 naturally (IDXW-bit arithmetic, WIDTH power of 2).
- WIDTH=1: IDXW=1. ptr stays 0. grant_index[0]=0, grant_valid[0]=data_in[0].
- GRANT_NUM=WIDTH with data_in all ones: grants are the full rotation from ptr. After accept, ptr returns to the same value (last+1 = ptr).
- data_in may change every cycle. The grant set used for the ptr update is the one visible in the same cycle as accept.
- No X on outputs after reset for any data_in.

Decomposition:
- Use the existing `max macro from the common header for IDXW. No new package typedefs required.
- Shared package constant: none. The grant index type is local, logic[IDXW-1:0].
- Sub-module: rr_single_finder (data_in, start, mode parameters → index, valid). One rotated-start single-grant search.
- Top instantiates rr_single_finder GRANT_NUM times in a generate chain. Stage k sees data_in with stages 0..k-1 grant bits cleared.
- Top owns the ptr register, last-valid-grant selection, and grant_mask OR.

Test Plan (defaults WIDTH=8, GRANT_NUM=2, ROUND_ROBIN=1 unless stated):
- rst pulsed between clock edges with ptr=5 and data_in=8'hFF → ptr=0 immediately, before the next edge. grants 0,1 valid; grant_mask=8'h03.
- ptr=0, data_in=8'hA4, accept=1 → grants 2,5, mask 8'h24; next ptr=6. Same data next cycle → grants 7,2, mask 8'h84.
- Wrap: ptr=6, data_in=8'h41, accept=1 → grants 6,0; next ptr=1.
- Single request: ptr=1, data_in=8'h10, accept=1 → grant0=4 valid, grant_valid=2'b01; next ptr=5.
- data_in=0, accept=1 → grant_valid=0, mask=0, ptr unchanged. Then data_in=8'hFF, accept=1, flush=1 → next ptr=0 (flush wins).
- ROUND_ROBIN=0, FIRST_PRIORITY=0, data_in=8'h8C, accept=1 for 3 cycles → grants 7,3 every cycle; ptr stays 0.

Source files
------------

// File: rtl/rr_multi_priority_finder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_multi_priority_finder_pkg
// Brief   : Shared helpers for the multi-grant round-robin priority finder.
// Revision: 1.0 - initial release
// ============================================================================
package rr_multi_priority_finder_pkg;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bit position visited at step 'step' of the search.
    function automatic int search_pos(input int step, input int start, input int width,
                                      input bit round_robin, input bit first_priority);
        if (round_robin)
            return (start + step) % width;
        else if (first_priority)
            return step;
        else
            return width - 1 - step;
    endfunction

endpackage : rr_multi_priority_finder_pkg
`default_nettype wire

// File: rtl/rr_multi_priority_finder_single.sv
`default_nettype none
// ============================================================================
// Module  : rr_single_finder
// Brief   : One rotated-start (or fixed-end) single-grant search stage.
// Revision: 1.0 - initial release
// ============================================================================
module rr_single_finder
    import rr_multi_priority_finder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int IDXW           = 3,
    parameter bit ROUND_ROBIN    = 1'b1,
    parameter bit FIRST_PRIORITY = 1'b1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [IDXW-1:0]  start,
    output logic [IDXW-1:0]  index,
    output logic             valid
);

    int w_pos;

    always_comb begin
        index = '0;
        valid = 1'b0;
        w_pos = 0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pos = search_pos(i, int'(start), WIDTH, ROUND_ROBIN, FIRST_PRIORITY);
            if (!valid && data_in[w_pos]) begin
                valid = 1'b1;
                index = IDXW'(w_pos);
            end
        end
    end

endmodule : rr_single_finder
`default_nettype wire

// File: rtl/rr_multi_priority_finder.sv
`default_nettype none
// ============================================================================
// Module  : rr_multi_priority_finder
// Brief   : Selects up to GRANT_NUM requests per cycle, round-robin or fixed.
// Revision: 1.0 - initial release
// ============================================================================
module rr_multi_priority_finder
    import rr_multi_priority_finder_pkg::*;
#(
    parameter int  WIDTH          = 8,
    parameter int  GRANT_NUM      = 2,
    parameter bit  ROUND_ROBIN    = 1'b1,
    parameter bit  FIRST_PRIORITY = 1'b1,
    localparam int IDXW           = max_int($clog2(WIDTH), 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH-1:0]                data_in,
    input  logic                            accept,
    input  logic                            flush,
    output logic [GRANT_NUM-1:0][IDXW-1:0]  grant_index,
    output logic [GRANT_NUM-1:0]            grant_valid,
    output logic [WIDTH-1:0]                grant_mask,
    output logic [IDXW-1:0]                 ptr
);

    logic [IDXW-1:0]  ptr_q;
    logic [IDXW-1:0]  ptr_d;
    logic [IDXW-1:0]  w_last;
    logic [WIDTH-1:0] w_remaining [GRANT_NUM+1];
    logic [IDXW-1:0]  w_index     [GRANT_NUM];
    logic             w_valid     [GRANT_NUM];

    assign w_remaining[0] = data_in;

    // Each stage searches what the earlier stages left behind.
    generate
        for (genvar k = 0; k < GRANT_NUM; k++) begin : g_stage
            rr_single_finder #(
                .WIDTH          (WIDTH),
                .IDXW           (IDXW),
                .ROUND_ROBIN    (ROUND_ROBIN),
                .FIRST_PRIORITY (FIRST_PRIORITY)
            ) u_finder (
                .data_in (w_remaining[k]),
                .start   (ptr_q),
                .index   (w_index[k]),
                .valid   (w_valid[k])
            );

            assign w_remaining[k+1] = w_valid[k]
                                    ? (w_remaining[k] & ~(WIDTH'(1) << w_index[k]))
                                    : w_remaining[k];
            assign grant_index[k]   = w_index[k];
            assign grant_valid[k]   = w_valid[k];
        end
    endgenerate

    assign grant_mask = data_in & ~w_remaining[GRANT_NUM];
    assign ptr        = ptr_q;

    always_comb begin
        w_last = '0;
        for (int k = 0; k < GRANT_NUM; k++) begin
            if (w_valid[k])
                w_last = w_index[k];
        end
    end

    // Modulo rather than IDXW wrap keeps WIDTH=1 pinned at zero.
    always_comb begin
        ptr_d = ptr_q;
        if (ROUND_ROBIN) begin
            if (flush)
                ptr_d = '0;
            else if (accept && w_valid[0])
                ptr_d = IDXW'((int'(w_last) + 1) % WIDTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

endmodule : rr_multi_priority_finder
`default_nettype wire
